// File: rtl/wino_pkg.sv
// Shared definitions for the Winograd partial-sum accumulator: default tile
// geometry, controller state encoding and the saturating element adder.
package wino_pkg;

  localparam int OUT_BIT     = 24;
  localparam int RESULT_SIZE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Operands arrive sign-extended to 64 bits; the result is clamped to a signed
  // field of the given width and the caller keeps the low bits.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 width,
    output logic               clamped
  );
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum     = a + b;
    max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v   = -max_v - 64'sd1;
    clamped = 1'b0;
    if (sum > max_v) begin
      sum     = max_v;
      clamped = 1'b1;
    end else if (sum < min_v) begin
      sum     = min_v;
      clamped = 1'b1;
    end
    return sum;
  endfunction

endpackage

// File: rtl/psum_ram.sv
// Simple dual-port partial-sum buffer: one write port, one read port with a
// registered read that only updates when a read is issued.
module psum_ram #(
  parameter  int DEPTH = 1024,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/wino_psum_accum.sv
// Accumulates Winograd tile results across input-channel passes, adds bias on
// the first pass and emits saturated, optionally ReLU'd and pooled tiles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a configuration handshake
// ST_RUN   | accepting tile inputs for all passes
// ST_DRAIN | all inputs taken, waiting for the last output to be accepted
module wino_psum_accum #(
  parameter  int X_PE        = 8,
  parameter  int OUT_BIT     = wino_pkg::OUT_BIT,
  parameter  int RESULT_SIZE = wino_pkg::RESULT_SIZE,
  parameter  int BIAS_BIT    = 20,
  parameter  int DEPTH       = 1024,
  localparam int AW          = $clog2(DEPTH),
  localparam int E           = RESULT_SIZE * RESULT_SIZE,
  localparam int DW          = OUT_BIT * E * X_PE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [AW:0]              cfg_tiles,
  input  logic [15:0]              cfg_passes,
  input  logic                     cfg_relu,
  input  logic                     cfg_pool,
  input  logic [BIAS_BIT*X_PE-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [OUT_BIT*X_PE-1:0]  out_pool,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  import wino_pkg::*;

  state_t                    state;
  logic [AW:0]               tiles_q;
  logic [15:0]               passes_q;
  logic                      relu_q;
  logic                      pool_q;
  logic [BIAS_BIT*X_PE-1:0]  bias_q;
  logic [AW-1:0]             t_cnt;
  logic [15:0]               p_cnt;

  logic                      s1_valid;
  logic                      s1_first;
  logic                      s1_last;
  logic                      s1_end;
  logic                      s1_fwd;
  logic [AW-1:0]             s1_t;
  logic [DW-1:0]             s1_data;
  logic [DW-1:0]             fwd_data;
  logic                      out_end;

  logic [DW-1:0]             rd_data;
  logic [DW-1:0]             sum_data;
  logic [DW-1:0]             fin_data;
  logic [OUT_BIT*X_PE-1:0]   fin_pool;
  logic                      sat_any;

  logic                      stall;
  logic                      advance;
  logic                      accept;
  logic                      wr_en;
  logic                      t_wrap;
  logic                      last_in;

  assign stall     = out_valid && !out_ready;
  assign advance   = !stall;
  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign in_ready  = (state == ST_RUN) && advance;
  assign accept    = in_valid && in_ready;
  assign t_wrap    = ({1'b0, t_cnt} == tiles_q - (AW+1)'(1));
  assign last_in   = t_wrap && (p_cnt == passes_q - 16'd1);
  assign wr_en     = s1_valid && !s1_last && advance;

  psum_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_psum_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (s1_t),
    .wr_data (sum_data),
    .rd_en   (accept),
    .rd_addr (t_cnt),
    .rd_data (rd_data)
  );

  logic signed [63:0]         prev_v;
  logic signed [63:0]         in_v;
  logic signed [63:0]         sum_v;
  logic signed [OUT_BIT-1:0]  in_e;
  logic signed [OUT_BIT-1:0]  old_e;
  logic signed [OUT_BIT-1:0]  elem;
  logic signed [OUT_BIT-1:0]  lane_max;
  logic signed [BIAS_BIT-1:0] bias_l;
  logic                       clamp_e;

  // The previous-pass operand comes from bias (pass 0), the forwarded write of
  // the preceding cycle (same tile re-read immediately), or the buffer.
  always_comb begin
    sum_data = '0;
    fin_data = '0;
    fin_pool = '0;
    sat_any  = 1'b0;
    prev_v   = '0;
    in_v     = '0;
    sum_v    = '0;
    in_e     = '0;
    old_e    = '0;
    elem     = '0;
    lane_max = '0;
    bias_l   = '0;
    clamp_e  = 1'b0;
    for (int l = 0; l < X_PE; l++) begin
      bias_l   = bias_q[l*BIAS_BIT +: BIAS_BIT];
      lane_max = '0;
      for (int e = 0; e < E; e++) begin
        in_e = s1_data[(l*E+e)*OUT_BIT +: OUT_BIT];
        in_v = 64'(in_e);
        if (s1_first) begin
          prev_v = 64'(bias_l);
        end else begin
          old_e  = s1_fwd ? fwd_data[(l*E+e)*OUT_BIT +: OUT_BIT]
                          : rd_data[(l*E+e)*OUT_BIT +: OUT_BIT];
          prev_v = 64'(old_e);
        end
        sum_v   = sat_add(prev_v, in_v, OUT_BIT, clamp_e);
        sat_any = sat_any | clamp_e;
        elem    = sum_v[OUT_BIT-1:0];
        sum_data[(l*E+e)*OUT_BIT +: OUT_BIT] = elem;
        if (relu_q && elem[OUT_BIT-1]) elem = '0;
        fin_data[(l*E+e)*OUT_BIT +: OUT_BIT] = elem;
        if (e == 0 || elem > lane_max) lane_max = elem;
      end
      if (pool_q) fin_pool[l*OUT_BIT +: OUT_BIT] = lane_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tiles_q   <= (AW+1)'(1);
      passes_q  <= 16'd1;
      relu_q    <= 1'b0;
      pool_q    <= 1'b0;
      bias_q    <= '0;
      t_cnt     <= '0;
      p_cnt     <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_end    <= 1'b0;
      s1_fwd    <= 1'b0;
      s1_t      <= '0;
      s1_data   <= '0;
      fwd_data  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pool  <= '0;
      out_end   <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            state    <= ST_RUN;
            tiles_q  <= (cfg_tiles == '0) ? (AW+1)'(1) : cfg_tiles;
            passes_q <= (cfg_passes == 16'd0) ? 16'd1 : cfg_passes;
            relu_q   <= cfg_relu;
            pool_q   <= cfg_pool;
            bias_q   <= bias;
            t_cnt    <= '0;
            p_cnt    <= '0;
            sat_flag <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept && last_in) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (out_valid && out_ready && out_end) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        if (t_wrap) begin
          t_cnt <= '0;
          p_cnt <= p_cnt + 16'd1;
        end else begin
          t_cnt <= t_cnt + AW'(1);
        end
      end

      if (advance) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data  <= in_data;
          s1_t     <= t_cnt;
          s1_first <= (p_cnt == 16'd0);
          s1_last  <= (p_cnt == passes_q - 16'd1);
          s1_end   <= last_in;
          s1_fwd   <= wr_en && (s1_t == t_cnt);
          fwd_data <= sum_data;
        end
        out_valid <= s1_valid && s1_last;
        if (s1_valid && s1_last) begin
          out_data <= fin_data;
          out_pool <= fin_pool;
          out_end  <= s1_end;
        end
        if (s1_valid && sat_any) sat_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wino_psum_accum.sv
// Self-checking bench for wino_psum_accum: directed vector table, hand-written
// corner sequences and randomized jobs against an arithmetic reference model.
module tb_wino_psum_accum;

  localparam int X_PE     = 2;
  localparam int OUT_BIT  = 24;
  localparam int RS       = 2;
  localparam int BIAS_BIT = 20;
  localparam int DEPTH    = 16;
  localparam int AW       = $clog2(DEPTH);
  localparam int E        = RS * RS;
  localparam int NEL      = X_PE * E;
  localparam int DW       = OUT_BIT * NEL;
  localparam int PW       = OUT_BIT * X_PE;
  localparam int BW       = BIAS_BIT * X_PE;
  localparam longint SMAX = (longint'(1) <<< (OUT_BIT - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;

  logic          clk;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW:0]   cfg_tiles;
  logic [15:0]   cfg_passes;
  logic          cfg_relu;
  logic          cfg_pool;
  logic [BW-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pool;
  logic          busy;
  logic          done;
  logic          sat_flag;

  wino_psum_accum #(
    .X_PE        (X_PE),
    .OUT_BIT     (OUT_BIT),
    .RESULT_SIZE (RS),
    .BIAS_BIT    (BIAS_BIT),
    .DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_tiles  (cfg_tiles),
    .cfg_passes (cfg_passes),
    .cfg_relu   (cfg_relu),
    .cfg_pool   (cfg_pool),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_pool   (out_pool),
    .busy       (busy),
    .done       (done),
    .sat_flag   (sat_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] pool;
    bit            last;
  } exp_t;

  typedef struct {
    int passes;
    bit relu;
    bit pool;
    int bias_v;
    int in_e[E];
    int exp_e[E];
    int pool_v;
    bit sat;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   rdy_mode = 0;
  bit   pend_done = 0;
  int   vin [4][8][NEL];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [DW-1:0] pack(input int v[NEL]);
    logic [DW-1:0] r;
    r = '0;
    for (int n = 0; n < NEL; n++) r[n*OUT_BIT +: OUT_BIT] = OUT_BIT'(v[n]);
    return r;
  endfunction

  function automatic longint clampv(input longint v, inout bit s);
    if (v > SMAX) begin s = 1'b1; return SMAX; end
    if (v < SMIN) begin s = 1'b1; return SMIN; end
    return v;
  endfunction

  // Reference: per element, bias + sum over passes with saturation at each add.
  task automatic model_push(input int tiles, input int passes, input bit relu, input bit pool,
                            input int bl[X_PE], output bit sat);
    int et, ep;
    et  = (tiles == 0) ? 1 : tiles;
    ep  = (passes == 0) ? 1 : passes;
    sat = 1'b0;
    for (int t = 0; t < et; t++) begin
      int            r[NEL];
      logic [PW-1:0] pl;
      longint        acc, mx;
      pl = '0;
      for (int n = 0; n < NEL; n++) begin
        acc = clampv(longint'(vin[0][t][n]) + longint'(bl[n / E]), sat);
        for (int p = 1; p < ep; p++) acc = clampv(acc + longint'(vin[p][t][n]), sat);
        if (relu && acc < 0) acc = 0;
        r[n] = int'(acc);
      end
      for (int l = 0; l < X_PE; l++) begin
        mx = r[l*E];
        for (int e = 1; e < E; e++) if (r[l*E+e] > mx) mx = r[l*E+e];
        if (pool) pl[l*OUT_BIT +: OUT_BIT] = OUT_BIT'(mx);
      end
      exp_q.push_back('{pack(r), pl, (t == et - 1)});
    end
  endtask

  // Output side: drives out_ready, scoreboards accepted outputs, checks
  // hold-stability under backpressure and the done pulse.
  initial begin
    logic [DW-1:0] held_data;
    logic [PW-1:0] held_pool;
    bit            held;
    exp_t          e;
    held      = 1'b0;
    held_data = '0;
    held_pool = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held      = 1'b0;
        pend_done = 1'b0;
        continue;
      end
      if (done || pend_done) check("done_pulse", DW'(done), DW'(pend_done));
      pend_done = 1'b0;
      if (held) begin
        check("hold_valid", DW'(out_valid), DW'(1));
        check("hold_data", out_data, held_data);
        check("hold_pool", DW'(out_pool), DW'(held_pool));
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      #1;
      if (out_valid && !out_ready) check("stall_in_ready", DW'(in_ready), DW'(0));
      held      = out_valid && !out_ready;
      held_data = out_data;
      held_pool = out_pool;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_pool", DW'(out_pool), DW'(e.pool));
          pend_done = e.last;
        end
      end
    end
  end

  task automatic do_cfg(input int tiles, input int passes, input bit relu, input bit pool,
                        input logic [BW-1:0] b);
    int c;
    c = 0;
    while (!cfg_ready && c < 200) begin @(posedge clk); #1; c++; end
    if (!cfg_ready) fail_timeout("cfg_ready_wait");
    cfg_tiles  = (AW+1)'(tiles);
    cfg_passes = 16'(passes);
    cfg_relu   = relu;
    cfg_pool   = pool;
    bias       = b;
    cfg_valid  = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("busy_after_cfg", DW'(busy), DW'(1));
    check("cfg_ready_in_run", DW'(cfg_ready), DW'(0));
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk); #2;
      if (in_ready) begin @(posedge clk); #1; ok = 1'b1; end
    end
    in_valid = 1'b0;
    if (!ok) fail_timeout("send");
  endtask

  task automatic wait_job();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || busy) && c < 2000) begin @(posedge clk); #1; c++; end
    if (exp_q.size() != 0 || busy) begin
      fail_timeout("job_complete");
      exp_q.delete();
    end
    @(negedge clk); #2;
  endtask

  task automatic send_job(input int tiles, input int passes);
    int et, ep;
    et = (tiles == 0) ? 1 : tiles;
    ep = (passes == 0) ? 1 : passes;
    for (int p = 0; p < ep; p++)
      for (int t = 0; t < et; t++) send(pack(vin[p][t]));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    check("rst_cfg_ready", DW'(cfg_ready), DW'(1));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_sat_flag", DW'(sat_flag), DW'(0));
    check("rst_out_data", out_data, DW'(0));
    check("rst_out_pool", DW'(out_pool), DW'(0));
    rst_n = 1'b1;
  endtask

  task automatic random_job();
    int            tiles, passes, r;
    bit            relu, pool, sat_exp;
    int            bl[X_PE];
    logic [BW-1:0] bv;
    tiles  = $urandom_range(0, 6);
    passes = $urandom_range(0, 4);
    relu   = 1'($urandom_range(0, 1));
    pool   = 1'($urandom_range(0, 1));
    bv     = '0;
    for (int l = 0; l < X_PE; l++) begin
      bl[l] = int'($urandom_range(0, (1 << BIAS_BIT) - 1)) - (1 << (BIAS_BIT - 1));
      bv[l*BIAS_BIT +: BIAS_BIT] = BIAS_BIT'(bl[l]);
    end
    for (int p = 0; p < 4; p++)
      for (int t = 0; t < 8; t++)
        for (int n = 0; n < NEL; n++) begin
          r = int'($urandom_range(0, 3));
          vin[p][t][n] = (r == 0) ? int'($urandom_range(0, (1 << OUT_BIT) - 1)) - (1 << (OUT_BIT - 1))
                                  : int'($urandom_range(0, 2000)) - 1000;
        end
    model_push(tiles, passes, relu, pool, bl, sat_exp);
    do_cfg(tiles, passes, relu, pool, bv);
    send_job(tiles, passes);
    wait_job();
    check("rand_sat_flag", DW'(sat_flag), DW'(sat_exp));
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    int a[NEL];
    for (int n = 0; n < NEL; n++) a[n] = v;
    return pack(a);
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vt[6];
    int            ev[NEL];
    logic [PW-1:0] pl;
    logic [BW-1:0] bv;
    int            c;

    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_tiles  = '0;
    cfg_passes = '0;
    cfg_relu   = 1'b0;
    cfg_pool   = 1'b0;
    bias       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(posedge clk);
    do_reset();

    vt[0] = '{1, 0, 0, 10, '{5, 5, 5, 5}, '{15, 15, 15, 15}, 0, 0};
    vt[1] = '{1, 1, 1, 0, '{-4, 3, 7, -1}, '{0, 3, 7, 0}, 7, 0};
    vt[2] = '{2, 0, 0, 0, '{8388607, 8388607, 8388607, 8388607},
              '{8388607, 8388607, 8388607, 8388607}, 0, 1};
    vt[3] = '{2, 0, 1, 0, '{-8388608, -8388608, -8388608, -8388608},
              '{-8388608, -8388608, -8388608, -8388608}, -8388608, 1};
    vt[4] = '{1, 0, 1, 0, '{-4, -3, -7, -1}, '{-4, -3, -7, -1}, -1, 0};
    vt[5] = '{3, 1, 1, -5, '{1, 2, -3, 0}, '{0, 1, 0, 0}, 1, 0};

    for (int i = 0; i < 6; i++) begin
      pl = '0;
      bv = '0;
      for (int l = 0; l < X_PE; l++) begin
        bv[l*BIAS_BIT +: BIAS_BIT] = BIAS_BIT'(vt[i].bias_v);
        pl[l*OUT_BIT +: OUT_BIT]   = OUT_BIT'(vt[i].pool_v);
      end
      for (int n = 0; n < NEL; n++) begin
        ev[n] = vt[i].exp_e[n % E];
        for (int p = 0; p < vt[i].passes; p++) vin[p][0][n] = vt[i].in_e[n % E];
      end
      exp_q.push_back('{pack(ev), pl, 1'b1});
      do_cfg(1, vt[i].passes, vt[i].relu, vt[i].pool, bv);
      send_job(1, vt[i].passes);
      wait_job();
      check("vec_sat_flag", DW'(sat_flag), DW'(vt[i].sat));
    end

    // Four single-pass tiles with bias; also pins the two-cycle latency.
    for (int l = 0; l < X_PE; l++) bv[l*BIAS_BIT +: BIAS_BIT] = BIAS_BIT'(10);
    for (int t = 0; t < 4; t++) exp_q.push_back('{rep(15), PW'(0), (t == 3)});
    do_cfg(4, 1, 1'b0, 1'b0, bv);
    send(rep(5));
    check("latency_n1", DW'(out_valid), DW'(0));
    @(posedge clk); #1;
    check("latency_n2", DW'(out_valid), DW'(1));
    for (int t = 1; t < 4; t++) send(rep(5));
    wait_job();

    // Three tiles, three passes: 1 + 2 + 3.
    for (int t = 0; t < 3; t++) exp_q.push_back('{rep(6), PW'(0), (t == 2)});
    do_cfg(3, 3, 1'b0, 1'b0, BW'(0));
    for (int p = 1; p <= 3; p++)
      for (int t = 0; t < 3; t++) send(rep(p));
    wait_job();

    // Single tile, back-to-back passes, output held off for three cycles.
    rdy_mode = 2;
    exp_q.push_back('{rep(8), PW'(0), 1'b1});
    do_cfg(1, 4, 1'b0, 1'b0, BW'(0));
    for (int p = 0; p < 4; p++) send(rep(2));
    c = 0;
    while (!out_valid && c < 50) begin @(negedge clk); #2; c++; end
    if (!out_valid) fail_timeout("stall_out_valid");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #2;
      check("stall_valid", DW'(out_valid), DW'(1));
      check("stall_in_ready_low", DW'(in_ready), DW'(0));
      check("stall_data", out_data, rep(8));
    end
    rdy_mode = 0;
    wait_job();

    // Reset in the middle of a saturating first pass, then a fresh job.
    for (int l = 0; l < X_PE; l++) bv[l*BIAS_BIT +: BIAS_BIT] = BIAS_BIT'(10);
    do_cfg(4, 2, 1'b0, 1'b0, bv);
    for (int t = 0; t < 3; t++) send(rep(8388607));
    @(posedge clk); #1;
    check("sat_before_reset", DW'(sat_flag), DW'(1));
    do_reset();
    random_job();

    rdy_mode = 1;
    for (int j = 0; j < 20; j++) random_job();
    rdy_mode = 0;
    for (int j = 0; j < 5; j++) random_job();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
